instr_prefetch_queue: RTL and testbench

Small synchronous FIFO between the instruction-fetch stage (program counter plus instruction memory) and the decode stage. Buffers fetched {PC, instruction} pairs so fetch can run ahead of a stalled decode, and discards all buffered work on a branch/jump redirect. Uses a valid/ready handshake on both sides and exposes an occupancy count for hazard logic.

---
 rtl/mips_pkg.sv | 6 +
 rtl/instr_prefetch_queue.sv | 80 ++++++++
 tb/tb_instr_prefetch_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the fetch/decode front end.
package mips_pkg;
   localparam int INSTR_WIDTH = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int PREFETCH_DEPTH = 4;
endpackage

// File: rtl/instr_prefetch_queue.sv
// Prefetch FIFO of {PC, instruction} pairs between fetch and decode.
// The whole queue is discarded on a branch/jump redirect (Flush).
module instr_prefetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = PREFETCH_DEPTH,
   parameter int WIDTH = INSTR_WIDTH
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Flush,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [WIDTH-1:0]         InPC,
   input  logic [WIDTH-1:0]         InInstruction,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [WIDTH-1:0]         OutPC,
   output logic [WIDTH-1:0]         OutInstruction,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] pc_mem    [DEPTH];
   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   // DEPTH is a power of two, so natural overflow gives the modulo wrap.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return p + PW'(1);
   endfunction

   assign InReady  = (count_q < FULL_CNT);
   assign OutValid = (count_q != '0);
   assign Count    = count_q;
   assign push     = InValid && InReady;
   assign pop      = OutValid && OutReady;

   // Empty queue presents a NOP so decode sees harmless data.
   assign OutPC          = OutValid ? pc_mem[rd_ptr]    : '0;
   assign OutInstruction = OutValid ? instr_mem[rd_ptr] : WIDTH'(NOP_INSTR);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (Flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]    <= InPC;
            instr_mem[wr_ptr] <= InInstruction;
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_prefetch_queue;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic             Clk = 1'b0;
   logic             Reset, Flush, InValid, InReady, OutValid, OutReady;
   logic [WIDTH-1:0] InPC, InInstruction, OutPC, OutInstruction;
   logic [2:0]       Count;

   int checks = 0;
   int errors = 0;
   bit checking = 0;

   logic [63:0] model_q[$];

   instr_prefetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .Clk(Clk), .Reset(Reset), .Flush(Flush),
      .InValid(InValid), .InReady(InReady), .InPC(InPC), .InInstruction(InInstruction),
      .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
      .OutInstruction(OutInstruction), .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of {pc, instr}.
   always @(posedge Clk) begin
      if (Reset || Flush) begin
         model_q.delete();
      end else begin
         bit do_push, do_pop;
         do_push = InValid && (model_q.size() < DEPTH);
         do_pop  = OutReady && (model_q.size() > 0);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({InPC, InInstruction});
      end
      checking = 1;
   end

   always @(negedge Clk) begin
      if (checking) begin
         logic [63:0] head;
         head = (model_q.size() > 0) ? model_q[0] : 64'h0;
         chk("count", 64'(Count), 64'(model_q.size()));
         chk("out_valid", 64'(OutValid), 64'(model_q.size() != 0));
         chk("in_ready", 64'(InReady), 64'(model_q.size() < DEPTH));
         chk("out_pc", 64'(OutPC), 64'(head[63:32]));
         chk("out_instr", 64'(OutInstruction), 64'(head[31:0]));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_n(input int n, input logic [31:0] pc0);
      for (int i = 0; i < n; i++) begin
         InValid = 1; InPC = pc0 + 32'(4 * i); InInstruction = 32'h2008_0001 + 32'(i);
         step();
      end
      InValid = 0;
   endtask

   initial begin
      Reset = 1; Flush = 0; InValid = 0; OutReady = 0; InPC = '0; InInstruction = '0;
      repeat (3) step();
      Reset = 0;
      step();
      chk("idle_count", 64'(Count), 64'd0);
      chk("idle_valid", 64'(OutValid), 64'd0);
      chk("idle_ready", 64'(InReady), 64'd1);
      chk("idle_instr", 64'(OutInstruction), 64'd0);

      // Fill to full, then a refused fifth push.
      push_n(4, 32'h0);
      chk("full_count", 64'(Count), 64'd4);
      chk("full_ready", 64'(InReady), 64'd0);
      InValid = 1; InPC = 32'd16; InInstruction = 32'h2008_0005;
      step();
      InValid = 0;
      chk("refused_count", 64'(Count), 64'd4);
      chk("refused_head", 64'(OutPC), 64'd0);

      // Drain in order.
      OutReady = 1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(OutPC), 64'(4 * i));
         chk("drain_instr", 64'(OutInstruction), 64'(32'h2008_0001 + 32'(i)));
         step();
      end
      chk("drained_valid", 64'(OutValid), 64'd0);
      chk("drained_instr", 64'(OutInstruction), 64'd0);

      // Steady push/pop at occupancy 2, crossing the pointer wrap.
      OutReady = 0;
      push_n(2, 32'h200);
      OutReady = 1;
      for (int i = 0; i < 10; i++) begin
         InValid = 1; InPC = 32'h208 + 32'(4 * i); InInstruction = 32'h1000 + 32'(i);
         chk("stream_count", 64'(Count), 64'd2);
         chk("stream_trail", 64'(OutPC), 64'(InPC - 32'd8));
         step();
      end
      InValid = 0;
      step(); step();
      OutReady = 0;

      // Flush with 3 entries and a coincident push.
      push_n(3, 32'h300);
      Flush = 1; InValid = 1; InPC = 32'h40; InInstruction = 32'hdead_beef;
      step();
      Flush = 0; InValid = 0;
      chk("flush_count", 64'(Count), 64'd0);
      chk("flush_valid", 64'(OutValid), 64'd0);
      InValid = 1; InPC = 32'h100; InInstruction = 32'h2008_0100;
      step();
      InValid = 0;
      chk("post_flush_pc", 64'(OutPC), 64'h100);
      OutReady = 1; step(); OutReady = 0;

      // Reset has priority over Flush on a full queue.
      push_n(4, 32'h500);
      Reset = 1; Flush = 1;
      step();
      Reset = 0; Flush = 0;
      chk("rst_count", 64'(Count), 64'd0);
      chk("rst_ready", 64'(InReady), 64'd1);
      chk("rst_valid", 64'(OutValid), 64'd0);
      chk("rst_pc", 64'(OutPC), 64'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         InValid       = ($urandom_range(0, 3) != 0);
         OutReady      = ($urandom_range(0, 2) != 0);
         Flush         = ($urandom_range(0, 31) == 0);
         Reset         = ($urandom_range(0, 127) == 0);
         InPC          = $urandom;
         InInstruction = $urandom;
         step();
      end
      Reset = 0; Flush = 0; InValid = 0; OutReady = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
